// File: rtl/rn_rcv_ctrl_pkg.sv
// Shared defaults for the rename flush-recovery sequencer.
// The logical register width matches the 32-entry RAT used by the default core.
package rn_rcv_ctrl_pkg;

   // Logical register address width of the default core.
   localparam int RN_LRF_AW_DEFAULT = 5;

   // Four RAT entries are restored per walk cycle.
   localparam int RN_P_RESTORE_DEFAULT = 2;

   // Width of the completed-recovery statistics counter.
   localparam int RN_STAT_W_DEFAULT = 16;

endpackage

// File: rtl/rn_rcv_ctrl.sv
// Flush-recovery sequencer for the rename stage.
// After a flush it holds rename, waits for commit to drain, walks the
// arch-to-spec RAT copy one group per cycle, then pulses free-list rollback
// and busytable clear. A flush at any point restarts the sequence.
module rn_rcv_ctrl
    import rn_rcv_ctrl_pkg::*;
#(
    parameter int CONFIG_LRF_AW          = RN_LRF_AW_DEFAULT,
    parameter int CONFIG_P_RESTORE_WIDTH = RN_P_RESTORE_DEFAULT,
    parameter int CONFIG_STAT_W          = RN_STAT_W_DEFAULT
)
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     cmt_idle,
    output logic                     rn_hold,
    output logic                     rat_rst_we,
    output logic [CONFIG_LRF_AW-1:0] rat_rst_base,
    output logic                     fl_rollback,
    output logic                     bt_clear,
    output logic                     rcv_busy,
    output logic                     rcv_done,
    output logic [CONFIG_STAT_W-1:0] rcv_cnt
);

    localparam int CNT_W = CONFIG_LRF_AW - CONFIG_P_RESTORE_WIDTH;
    localparam logic [CNT_W-1:0] CNT_LAST = '1;
    localparam logic [CONFIG_STAT_W-1:0] STAT_SAT = '1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRAIN = 2'd1,
        S_WALK  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [CNT_W-1:0]         r_cnt;
    logic [CONFIG_STAT_W-1:0] r_rcv_cnt;
    logic                     w_flush;

    // A flush seen while reset is asserted must not raise any output.
    assign w_flush = flush & rst_n;

    // State, walk counter and statistics counter with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_rcv_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_flush || (r_state != S_WALK)) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            if ((r_state == S_DONE) && !w_flush && (r_rcv_cnt != STAT_SAT)) begin
                r_rcv_cnt <= r_rcv_cnt + 1'b1;
            end
        end
    end

    // Next-state selection; a flush anywhere restarts at DRAIN.
    always_comb begin
        w_state_nxt = r_state;
        if (w_flush) begin
            w_state_nxt = S_DRAIN;
        end else begin
            case (r_state)
                S_IDLE:  w_state_nxt = S_IDLE;
                S_DRAIN: w_state_nxt = cmt_idle ? S_WALK : S_DRAIN;
                S_WALK:  w_state_nxt = (r_cnt == CNT_LAST) ? S_DONE : S_WALK;
                S_DONE:  w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Moore outputs from the registered state, with flush gating the pulses.
    always_comb begin
        rn_hold      = w_flush | (r_state != S_IDLE);
        rcv_busy     = (r_state != S_IDLE);
        rat_rst_we   = 1'b0;
        rat_rst_base = '0;
        fl_rollback  = 1'b0;
        bt_clear     = 1'b0;
        rcv_done     = 1'b0;
        case (r_state)
            S_WALK: begin
                rat_rst_we   = ~w_flush;
                rat_rst_base = {r_cnt, {CONFIG_P_RESTORE_WIDTH{1'b0}}};
            end
            S_DONE: begin
                fl_rollback = ~w_flush;
                bt_clear    = ~w_flush;
                rcv_done    = ~w_flush;
            end
            default: begin
                rat_rst_we = 1'b0;
            end
        endcase
    end

    assign rcv_cnt = r_rcv_cnt;

endmodule

// File: doc/rn_rcv_ctrl.md
# rn_rcv_ctrl

Flush-recovery sequencer for the rename stage. After a pipeline flush it holds rename and waits for the commit stage to drain. It then walks the architectural-to-speculative RAT copy a few logical registers per cycle, and finishes by pulsing free-list rollback and busytable clear. It sits beside the rename stage and drives its stall and restore controls, replacing a single-cycle full-RAT rollback.

## Interface
Parameters:
- CONFIG_LRF_AW, default `NCPU_LRF_AW` (5): logical register address width; RAT has 2^CONFIG_LRF_AW entries.
- CONFIG_P_RESTORE_WIDTH, default 2: log2 of RAT entries restored per cycle (4).
- CONFIG_STAT_W, default 16: width of the recovery statistics counter.

Ports:
- clk  in  1  clock; single clock domain.
- rst_n  in  1  reset; synchronous, active-low.
- flush  in  1  single-cycle flush request from the commit stage.
- cmt_idle  in  1  high when the ROB is empty and no commit is in flight.
- rn_hold  out  1  stall request to rename; OR-ed into the rename stall.
- rat_rst_we  out  1  copy arch RAT to spec RAT for 2^P_RESTORE entries this cycle.
- rat_rst_base  out  CONFIG_LRF_AW  first logical index of this cycle's restore group; low P_RESTORE bits are always 0.
- fl_rollback  out  1  one-cycle free-list rollback pulse.
- bt_clear  out  1  one-cycle busytable clear pulse.
- rcv_busy  out  1  high in any state other than IDLE.
- rcv_done  out  1  one-cycle pulse when recovery completes.
- rcv_cnt  out  CONFIG_STAT_W  count of completed recoveries; saturates at all-ones.

## Operation
- States: IDLE, DRAIN, WALK, DONE. Encoding is local to the block.
- IDLE: all outputs low except rcv_cnt. flush=1 moves to DRAIN.
- DRAIN: waits for cmt_idle. If cmt_idle=1, moves to WALK with walk counter cnt=0. Otherwise stays in DRAIN; there is no timeout.
- WALK:
  - rat_rst_we=1 and rat_rst_base={cnt, P_RESTORE'b0}.
  - cnt increments by 1 each cycle.
  - When cnt equals 2^(LRF_AW-P_RESTORE)-1, moves to DONE.
- DONE:
  - fl_rollback=1, bt_clear=1, rcv_done=1.
  - rcv_cnt increments by 1 unless it is already saturated.
  - Next state is IDLE.
- rn_hold = flush | (state != IDLE). It goes high combinationally in the flush cycle itself.
- Flush in any non-IDLE state:
  - Restarts recovery: next state is DRAIN and cnt is cleared.
  - In that cycle rat_rst_we, fl_rollback, bt_clear and rcv_done are forced to 0.
  - rcv_cnt does not increment.
- Restore groups are consecutive and non-overlapping. Every logical index is covered exactly once per uninterrupted walk. Index 0 is included; the restore does not special-case r0.
- cnt width is CONFIG_LRF_AW-CONFIG_P_RESTORE_WIDTH. No wrap-around occurs because the walk ends at the max count.

## Timing
- Reset (rst_n=0 at a rising edge):
  - state=IDLE, cnt=0, rcv_cnt=0.
  - All outputs are 0 on the following cycle, regardless of flush.
- Reset mid-recovery aborts the walk with no pulses. The RAT is left partially restored; the system reset covers it.
- Flush at cycle T with cmt_idle=1 from T+1:
  - T+1: DRAIN.
  - T+2 to T+2+N-1: WALK, with N=2^(LRF_AW-P_RESTORE).
  - T+2+N: DONE.
  - T+3+N: IDLE, and rn_hold low.
- Flush-to-release latency is N+3 cycles, plus any extra DRAIN cycles.
- Moore outputs come from the registered state. The only exceptions are rn_hold and the flush gating, which are combinational.
- If flush and cmt_idle are high in the same IDLE cycle, cmt_idle is ignored; the DRAIN visit is always at least one cycle.

## Structure
- CONFIG_LRF_AW defaults from `NCPU_LRF_AW` in ncpu64k_config.vh. No new shared macros are added.
- The state encoding stays as localparams inside the block.
- One always-style register group covers state, cnt and rcv_cnt, all with synchronous active-low reset. The mDFF_lr primitive is not reused because its reset polarity differs.
- No sub-module; the block is flat.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with flush=1 -> every output is 0 and rcv_cnt=0.
- Basic recovery (defaults, cmt_idle=1): flush pulse at T -> rn_hold=1 from T through T+10.
  - rat_rst_we=1 at T+2..T+9 with rat_rst_base=0,4,...,28.
  - fl_rollback, bt_clear and rcv_done all 1 at T+10.
  - rn_hold=0 at T+11; rcv_cnt=1.
- Drain wait: flush at T, cmt_idle low until T+5 -> DRAIN lasts T+1..T+5, first rat_rst_we at T+6, rcv_done at T+14.
- Re-flush mid-walk: second flush while rat_rst_base=12 -> rat_rst_we=0 in that cycle.
  - The walk restarts from base 0 after DRAIN.
  - Exactly one rcv_done results, and rcv_cnt increments by 1.
- Flush in DONE cycle -> fl_rollback, bt_clear and rcv_done stay 0; a full 8-cycle walk follows.
- Saturation: CONFIG_STAT_W=2, run 5 recoveries -> rcv_cnt reads 1,2,3,3,3.
